// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Register file with a per-register pending-write (busy) scoreboard.
// After reset the block walks registers 1..NREG-1 writing zero (CLEAR state).
// It then enters RUN, where it accepts writebacks and issues.
// Register 0 is hard-wired to zero and is never busy.
//
// Ports
//   clk        in   single clock, all state changes on the rising edge
//   rst        in   asynchronous, active-high reset
//   rs1_addr   in   AW    read port 1 address
//   rs2_addr   in   AW    read port 2 address
//   rs1_data   out  XLEN  read port 1 data (combinational, write bypass)
//   rs2_data   out  XLEN  read port 2 data (combinational, write bypass)
//   rs1_busy   out  1     pending-write flag for rs1_addr
//   rs2_busy   out  1     pending-write flag for rs2_addr
//   wr_en      in   1     writeback strobe
//   wr_addr    in   AW    writeback address
//   wr_data    in   XLEN  writeback data
//   issue_en   in   1     issue strobe (marks destination pending)
//   issue_addr in   AW    issue destination address
//   ready      out  1     high once the post-reset clear sequence is done
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_addr,
    output logic            ready
);

    localparam int              NREG      = 2 ** AW;
    localparam logic [AW-1:0]   ZERO_ADDR = {AW{1'b0}};
    localparam logic [AW-1:0]   ONE_IDX   = AW'(32'd1);
    localparam logic [AW-1:0]   LAST_IDX  = {AW{1'b1}};
    localparam logic [XLEN-1:0] ZERO_DATA = {XLEN{1'b0}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    // Busy bits only exist for registers 1..NREG-1; register 0 is never busy.
    logic [NREG-1:1] busy_q, busy_d;
    // Storage is deliberately left without reset so it can map onto a RAM;
    // the CLEAR walk is what zeroes it. Entry 0 is never written or read.
    logic [XLEN-1:0] regs_q [0:NREG-1];

    logic            run_s;
    logic            wr_ok_s;
    logic            iss_ok_s;
    logic            byp1_s;
    logic            byp2_s;
    logic            mem_we_s;
    logic [AW-1:0]   mem_waddr_s;
    logic [XLEN-1:0] mem_wdata_s;

    // Look up the busy bit for an address; address 0 always returns 0.
    function automatic logic busy_at(input logic [NREG-1:1] vec,
                                     input logic [AW-1:0]   addr);
        logic hit;
        hit = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            hit = hit | (vec[i] & (addr == AW'(i)));
        end
        return hit;
    endfunction

    assign run_s    = (state_q == ST_RUN);
    assign ready    = run_s;
    // Writes and issues are honoured only in RUN and never for register 0.
    assign wr_ok_s  = run_s & wr_en & (wr_addr != ZERO_ADDR);
    assign iss_ok_s = run_s & issue_en & (issue_addr != ZERO_ADDR);
    assign byp1_s   = wr_ok_s & (wr_addr == rs1_addr);
    assign byp2_s   = wr_ok_s & (wr_addr == rs2_addr);

    // FSM next state and clear-walk index.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = ST_RUN;
                    clr_idx_d = clr_idx_q;
                end else begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = clr_idx_q + ONE_IDX;
                end
            end
            ST_RUN: begin
                state_d   = ST_RUN;
                clr_idx_d = clr_idx_q;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = ONE_IDX;
            end
        endcase
    end

    // Single storage write port: the clear walk owns it in CLEAR, writeback in RUN.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = clr_idx_q;
        mem_wdata_s = ZERO_DATA;
        if (!run_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_idx_q;
            mem_wdata_s = ZERO_DATA;
        end else if (wr_ok_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = wr_addr;
            mem_wdata_s = wr_data;
        end else begin
            mem_we_s    = 1'b0;
            mem_waddr_s = wr_addr;
            mem_wdata_s = wr_data;
        end
    end

    // Busy next state: issue sets, writeback clears, set wins on a collision.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREG; i++) begin
            busy_d[i] = (iss_ok_s && (issue_addr == AW'(i))) ? 1'b1 :
                        ((wr_ok_s && (wr_addr == AW'(i))) ? 1'b0 : busy_q[i]);
        end
    end

    // Read port 1: zero outside RUN or for register 0, else bypass or storage.
    always_comb begin
        rs1_data = ZERO_DATA;
        rs1_busy = 1'b0;
        if (run_s && (rs1_addr != ZERO_ADDR)) begin
            rs1_data = byp1_s ? wr_data : regs_q[rs1_addr];
            // A writeback landing this cycle already resolves the pending write.
            rs1_busy = busy_at(busy_q, rs1_addr) & ~byp1_s;
        end else begin
            rs1_data = ZERO_DATA;
            rs1_busy = 1'b0;
        end
    end

    // Read port 2: identical to port 1, fully independent.
    always_comb begin
        rs2_data = ZERO_DATA;
        rs2_busy = 1'b0;
        if (run_s && (rs2_addr != ZERO_ADDR)) begin
            rs2_data = byp2_s ? wr_data : regs_q[rs2_addr];
            rs2_busy = busy_at(busy_q, rs2_addr) & ~byp2_s;
        end else begin
            rs2_data = ZERO_DATA;
            rs2_busy = 1'b0;
        end
    end

    // Control state: FSM, clear index and busy bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= ONE_IDX;
            busy_q    <= {(NREG-1){1'b0}};
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    // Register storage write (no reset on purpose).
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            regs_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    regfile_scoreboard_chk #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .clr_idx  (clr_idx_q),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy)
    );

endmodule

// -----------------------------------------------------------------------------
// regfile_scoreboard_chk
//
// Invariant checks for regfile_scoreboard (simulation only, no logic).
// Ports: clk, rst, ready, clr_idx and the read-port addresses and outputs.
// -----------------------------------------------------------------------------
module regfile_scoreboard_chk #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input logic            clk,
    input logic            rst,
    input logic            ready,
    input logic [AW-1:0]   clr_idx,
    input logic [AW-1:0]   rs1_addr,
    input logic [AW-1:0]   rs2_addr,
    input logic [XLEN-1:0] rs1_data,
    input logic [XLEN-1:0] rs2_data,
    input logic            rs1_busy,
    input logic            rs2_busy
);

    // Register 0 reads zero and is never pending.
    a_reg0_rs1: assert property (@(posedge clk) disable iff (rst)
        (rs1_addr == {AW{1'b0}}) |-> ((rs1_data == {XLEN{1'b0}}) && !rs1_busy));
    a_reg0_rs2: assert property (@(posedge clk) disable iff (rst)
        (rs2_addr == {AW{1'b0}}) |-> ((rs2_data == {XLEN{1'b0}}) && !rs2_busy));

    // Before RUN every read output is quiet.
    a_quiet_clear: assert property (@(posedge clk) disable iff (rst)
        !ready |-> ((rs1_data == {XLEN{1'b0}}) && (rs2_data == {XLEN{1'b0}})
                    && !rs1_busy && !rs2_busy));

    // RUN is left only through reset.
    a_run_sticky: assert property (@(posedge clk) disable iff (rst)
        ready |=> ready);

    // The clear walk never targets register 0.
    a_clr_idx_nz: assert property (@(posedge clk) disable iff (rst)
        !ready |-> (clr_idx != {AW{1'b0}}));

endmodule
